reg_writeback: RTL and testbench

- Write-side controller for the 32x32 MIPS register file. Merges single-cycle pipeline results and long-latency results into the file's single write port.
- Long-latency results come from mul/div and load-miss units and are buffered in a small FIFO.
- A 32-bit busy scoreboard lets decode stall on pending long-latency destinations.
- Sits between EX/MEM/long units and the register file's write_addr3/write_data/write_enable inputs.

---
 rtl/reg_writeback.sv | 148 ++++++++++++++
 tb/tb_reg_writeback.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback
//   Write-side controller for the 32x32 register file. It merges
//   single-cycle pipeline results and buffered long-latency results
//   (mul/div, load miss) into the file's single write port. It also keeps
//   a busy scoreboard so decode can stall on pending long-latency
//   destinations.
//
// Ports
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   p_valid/p_addr/p_data     single-cycle pipeline result (highest priority)
//   l_valid/l_addr/l_data     long-latency result offered to the FIFO
//   l_ready                   FIFO can accept (count != DEPTH)
//   issue_valid/issue_addr    long-latency op issued; marks destination busy
//   chk_addr1/chk_addr2       decode source registers
//   busy1/busy2               scoreboard state for chk_addr1/chk_addr2
//   stall_req                 registered FIFO-full flag for upstream
//   write_addr3/write_data/
//   write_enable              register file write port (1-cycle latency)

module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          p_valid,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_data,
  input  logic          l_valid,
  output logic          l_ready,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          busy1,
  output logic          busy2,
  output logic          stall_req,
  output logic [AW-1:0] write_addr3,
  output logic [DW-1:0] write_data,
  output logic          write_enable
);

  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW   = PW + 1;
  localparam int              NREG = 1 << AW;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  // FIFO storage carries data only; occupancy is tracked by the pointers
  // and count, so the array itself needs no reset.
  logic [AW-1:0]   fifo_addr [DEPTH];
  logic [DW-1:0]   fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic            push_p0;
  logic            pop_p0;
  logic            vld_p0;
  logic            wr_p0;
  logic [AW-1:0]   head_addr_p0;
  logic [DW-1:0]   head_data_p0;
  logic [AW-1:0]   sel_addr_p0;
  logic [DW-1:0]   sel_data_p0;

  assign l_ready      = (count != FULL);
  assign head_addr_p0 = fifo_addr[rd_ptr];
  assign head_data_p0 = fifo_data[rd_ptr];

  // Scoreboard is read without bypassing a same-cycle pop, so decode sees
  // the clear in the same cycle the register file receives the value.
  assign busy1 = busy[chk_addr1];
  assign busy2 = busy[chk_addr2];

  // Stage p0: source selection, FIFO and scoreboard next-state
  always_comb begin
    push_p0     = l_valid && l_ready;
    // The pipeline always wins; the FIFO head drains only in its gaps.
    pop_p0      = !p_valid && (count != '0);
    vld_p0      = p_valid || pop_p0;
    sel_addr_p0 = p_valid ? p_addr : head_addr_p0;
    sel_data_p0 = p_valid ? p_data : head_data_p0;
    // r0 is hardwired zero: the entry is consumed but never written.
    wr_p0       = vld_p0 && (sel_addr_p0 != '0);

    count_next = count;
    case ({push_p0, pop_p0})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    busy_next = busy;
    if (pop_p0) begin
      busy_next[head_addr_p0] = 1'b0;
    end
    // Applied after the clear so a same-cycle re-issue keeps the bit set.
    if (issue_valid && (issue_addr != '0)) begin
      busy_next[issue_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (push_p0) begin
      fifo_addr[wr_ptr] <= l_addr;
      fifo_data[wr_ptr] <= l_data;
    end
  end

  // Stage p1: registered write port, pointers, scoreboard, stall flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      busy         <= '0;
      stall_req    <= 1'b0;
      write_enable <= 1'b0;
      write_addr3  <= '0;
      write_data   <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push_p0) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_p0) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count        <= count_next;
      busy         <= busy_next;
      stall_req    <= (count_next == FULL);
      write_enable <= wr_p0;
      // Address/data hold their last written value on idle cycles.
      if (wr_p0) begin
        write_addr3 <= sel_addr_p0;
        write_data  <= sel_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  logic        clock;
  logic        reset_n;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic [4:0]  write_addr3;
  logic [31:0] write_data;
  logic        write_enable;

  reg_writeback #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .p_valid      (p_valid),
    .p_addr       (p_addr),
    .p_data       (p_data),
    .l_valid      (l_valid),
    .l_ready      (l_ready),
    .l_addr       (l_addr),
    .l_data       (l_data),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .chk_addr1    (chk_addr1),
    .chk_addr2    (chk_addr2),
    .busy1        (busy1),
    .busy2        (busy2),
    .stall_req    (stall_req),
    .write_addr3  (write_addr3),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One record per clock edge: inputs driven before the edge, expected
  // outputs observed just after it (busy/l_ready use this record's chk addrs).
  typedef struct {
    logic        rn;
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk_ad;
    logic        stall;
    logic        lrdy;
    logic        b1;
    logic        b2;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl_end[$];
  vec_t exp_q[$];

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  // Reference model state for the random phase
  logic [4:0]  mq_a[$];
  logic [31:0] mq_d[$];
  logic [31:0] mbusy;
  logic [4:0]  mha;
  logic [31:0] mhd;
  logic        mstall;

  function automatic vec_t mkv(
    input logic [31:0] rn, pv, pa, pd, lv, la, ld, iv, ia, c1, c2,
    input logic [31:0] we, wa, wd, ca, st, lr, b1, b2);
    vec_t x;
    x.rn = rn[0]; x.pv = pv[0]; x.pa = pa[4:0]; x.pd = pd;
    x.lv = lv[0]; x.la = la[4:0]; x.ld = ld;
    x.iv = iv[0]; x.ia = ia[4:0]; x.c1 = c1[4:0]; x.c2 = c2[4:0];
    x.we = we[0]; x.wa = wa[4:0]; x.wd = wd; x.chk_ad = ca[0];
    x.stall = st[0]; x.lrdy = lr[0]; x.b1 = b1[0]; x.b2 = b2[0];
    return x;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  task automatic apply(input vec_t x, input int id);
    vec_t e;
    reset_n     = x.rn;
    p_valid     = x.pv;
    p_addr      = x.pa;
    p_data      = x.pd;
    l_valid     = x.lv;
    l_addr      = x.la;
    l_data      = x.ld;
    issue_valid = x.iv;
    issue_addr  = x.ia;
    chk_addr1   = x.c1;
    chk_addr2   = x.c2;
    exp_q.push_back(x);
    @(posedge clock);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard vec %0d: got empty queue want entry", id);
    end else begin
      e = exp_q.pop_front();
      cmp("write_enable", id, {31'd0, write_enable}, {31'd0, e.we});
      cmp("stall_req",    id, {31'd0, stall_req},    {31'd0, e.stall});
      cmp("l_ready",      id, {31'd0, l_ready},      {31'd0, e.lrdy});
      cmp("busy1",        id, {31'd0, busy1},        {31'd0, e.b1});
      cmp("busy2",        id, {31'd0, busy2},        {31'd0, e.b2});
      if (e.chk_ad) begin
        cmp("write_addr3", id, {27'd0, write_addr3}, {27'd0, e.wa});
        cmp("write_data",  id, write_data, e.wd);
      end
    end
  endtask

  task automatic model_reset();
    mq_a.delete();
    mq_d.delete();
    mbusy  = '0;
    mha    = '0;
    mhd    = '0;
    mstall = 1'b0;
  endtask

  // Behavioural model: queue-based FIFO, pipeline priority, r0 discard,
  // set-over-clear scoreboard.
  task automatic model_step(input vec_t xi, output vec_t xo);
    bit          push;
    bit          pop;
    bit          sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic [4:0]  ha;
    xo   = xi;
    push = xi.lv && (mq_a.size() != 4);
    pop  = !xi.pv && (mq_a.size() != 0);
    sv = 0; sa = '0; sd = '0; ha = '0;
    if (pop) ha = mq_a[0];
    if (xi.pv) begin
      sv = 1; sa = xi.pa; sd = xi.pd;
    end else if (pop) begin
      sv = 1; sa = ha; sd = mq_d[0];
    end
    xo.we = sv && (sa != 0);
    if (xo.we) begin
      mha = sa;
      mhd = sd;
    end
    if (pop) begin
      mbusy[ha] = 1'b0;
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (xi.iv && (xi.ia != 0)) mbusy[xi.ia] = 1'b1;
    if (push) begin
      mq_a.push_back(xi.la);
      mq_d.push_back(xi.ld);
    end
    mstall    = (mq_a.size() == 4);
    xo.wa     = mha;
    xo.wd     = mhd;
    xo.chk_ad = 1'b1;
    xo.stall  = mstall;
    xo.lrdy   = !mstall;
    xo.b1     = mbusy[xi.c1];
    xo.b2     = mbusy[xi.c2];
  endtask

  initial begin
    vec_t rv;
    vec_t ev;

    reset_n = 1'b0; p_valid = 1'b0; p_addr = '0; p_data = '0;
    l_valid = 1'b0; l_addr = '0; l_data = '0; issue_valid = 1'b0;
    issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;

    //       rn pv pa  pd            lv la  ld           iv ia c1 c2  we wa  wd            ca st lr b1 b2
    // reset held 2 cycles with p_valid asserted
    tbl.push_back(mkv(0, 1, 5, 32'h1234,     0, 0,  0,           0, 0, 7, 9,  0, 0,  0,            1, 0, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 5, 32'h1234,     0, 0,  0,           0, 0, 7, 9,  0, 0,  0,            1, 0, 1, 0, 0));
    // pipeline path, then idle hold
    tbl.push_back(mkv(1, 1, 5, 32'hDEADBEEF, 0, 0,  0,           0, 0, 0, 0,  1, 5,  32'hDEADBEEF, 1, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 0, 0,  0, 5,  32'hDEADBEEF, 1, 0, 1, 0, 0));
    // priority: buffered r7 waits behind two pipeline writes
    tbl.push_back(mkv(1, 0, 0, 0,            1, 7,  32'h11,      1, 7, 7, 0,  0, 5,  32'hDEADBEEF, 1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 3, 32'h33,       0, 0,  0,           0, 0, 7, 0,  1, 3,  32'h33,       1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 4, 32'h44,       0, 0,  0,           0, 0, 7, 0,  1, 4,  32'h44,       1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 7, 0,  1, 7,  32'h11,       1, 0, 1, 0, 0));
    // fill FIFO with r8..r11 under continuous pipeline writes
    tbl.push_back(mkv(1, 1, 20, 32'hA0,      1, 8,  32'h800,     1, 8, 8, 11, 1, 20, 32'hA0,       1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 21, 32'hA1,      1, 9,  32'h801,     1, 9, 8, 11, 1, 21, 32'hA1,       1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 22, 32'hA2,      1, 10, 32'h802,     1, 10, 8, 11, 1, 22, 32'hA2,      1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 23, 32'hA3,      1, 11, 32'h803,     1, 11, 8, 11, 1, 23, 32'hA3,      1, 1, 0, 1, 1));
    // drain; push offered while full must be dropped
    tbl.push_back(mkv(1, 0, 0, 0,            1, 12, 32'hBAD,     0, 0, 8, 11, 1, 8,  32'h800,      1, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 8, 11, 1, 9,  32'h801,      1, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 8, 11, 1, 10, 32'h802,      1, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 8, 11, 1, 11, 32'h803,      1, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 8, 11, 0, 11, 32'h803,      1, 0, 1, 0, 0));
    // register 0: FIFO entry and pipeline result both discarded
    tbl.push_back(mkv(1, 0, 0, 0,            1, 0,  32'h55,      1, 0, 0, 0,  0, 11, 32'h803,      1, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 32'h66,       0, 0,  0,           0, 0, 0, 0,  0, 0,  0,            0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 0, 0,  0, 0,  0,            0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            1, 13, 32'h130,     0, 0, 0, 0,  0, 0,  0,            0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 0, 0,  1, 13, 32'h130,      1, 0, 1, 0, 0));
    // scoreboard collision on r9: set beats clear
    tbl.push_back(mkv(1, 0, 0, 0,            1, 9,  32'h901,     1, 9, 9, 0,  0, 13, 32'h130,      1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 2, 32'h22,       1, 9,  32'h902,     0, 0, 9, 0,  1, 2,  32'h22,       1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           1, 9, 9, 0,  1, 9,  32'h901,      1, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 9, 0,  1, 9,  32'h902,      1, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0,            0, 0,  0,           0, 0, 9, 0,  0, 9,  32'h902,      1, 0, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,            0, 0,  0,           0, 0, 0, 0,  0, 0,  0,            1, 0, 1, 0, 0));

    // reset mid-operation discards buffered results and busy bits
    tbl_end.push_back(mkv(0, 0, 0, 0,        0, 0,  0,           0, 0, 0, 0,  0, 0,  0,            1, 0, 1, 0, 0));
    tbl_end.push_back(mkv(1, 1, 15, 32'hF0,  1, 14, 32'hE0,      1, 14, 14, 16, 1, 15, 32'hF0,     1, 0, 1, 1, 0));
    tbl_end.push_back(mkv(1, 1, 15, 32'hF1,  1, 16, 32'hE1,      1, 16, 14, 16, 1, 15, 32'hF1,     1, 0, 1, 1, 1));
    tbl_end.push_back(mkv(0, 0, 0, 0,        0, 0,  0,           0, 0, 14, 16, 0, 0,  0,           1, 0, 1, 0, 0));
    tbl_end.push_back(mkv(1, 0, 0, 0,        0, 0,  0,           0, 0, 14, 16, 0, 0,  0,           1, 0, 1, 0, 0));
    tbl_end.push_back(mkv(1, 0, 0, 0,        0, 0,  0,           0, 0, 14, 16, 0, 0,  0,           1, 0, 1, 0, 0));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // random traffic against the model, starting from the reset state above
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rv = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.pv = mstall ? 1'b0 : ($urandom_range(0, 1) == 1);
      rv.pa = 5'($urandom_range(0, 15));
      rv.pd = $urandom;
      rv.lv = ($urandom_range(0, 9) < 6);
      rv.la = 5'($urandom_range(0, 15));
      rv.ld = $urandom;
      rv.iv = ($urandom_range(0, 9) < 3);
      rv.ia = 5'($urandom_range(0, 15));
      rv.c1 = 5'($urandom_range(0, 15));
      rv.c2 = 5'($urandom_range(0, 15));
      model_step(rv, ev);
      apply(ev, 1000 + i);
    end

    for (int i = 0; i < tbl_end.size(); i++) begin
      apply(tbl_end[i], 2000 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
